// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract: the WIDTH-bit operation is resolved CW bits per stage, with the
// inter-chunk carry forwarded through registers. A single enable freezes the pipe on stall.
module pipelined_addsub #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned CW = (STAGES == 0) ? 1 : WIDTH / STAGES;

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipelined_addsub: WIDTH (%0d) must be a nonzero multiple of STAGES (%0d)",
           WIDTH, STAGES);
  end

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign b_eff    = sub ? ~b : b;
  assign c_eff    = sub | cin;

  // Operands presented to the final (output) stage.
  logic [WIDTH-1:0] last_x;
  logic [CW-1:0]    last_y;
  logic             last_c;
  logic             last_v;

  if (STAGES == 1) begin : g_single
    assign last_x = a;
    assign last_y = b_eff;
    assign last_c = c_eff;
    assign last_v = in_valid;
  end else begin : g_multi
    for (genvar k = 0; k < STAGES - 1; k++) begin : g_stage
      // x carries resolved sum chunks below k and raw operand-a chunks above;
      // y keeps only the operand-b chunks still to be consumed.
      localparam int unsigned YI = WIDTH - k * CW;
      localparam int unsigned YQ = YI - CW;

      logic [WIDTH-1:0] x_in;
      logic [WIDTH-1:0] x_nx;
      logic [WIDTH-1:0] x_q;
      logic [YI-1:0]    y_in;
      logic [YQ-1:0]    y_q;
      logic             c_in;
      logic             v_in;
      logic             c_q;
      logic             v_q;
      logic [CW:0]      sum;

      if (k == 0) begin : g_first
        assign x_in = a;
        assign y_in = b_eff;
        assign c_in = c_eff;
        assign v_in = in_valid;
      end else begin : g_next
        assign x_in = g_stage[k-1].x_q;
        assign y_in = g_stage[k-1].y_q;
        assign c_in = g_stage[k-1].c_q;
        assign v_in = g_stage[k-1].v_q;
      end

      always_comb begin
        sum  = {1'b0, x_in[k*CW +: CW]} + {1'b0, y_in[CW-1:0]} + {{CW{1'b0}}, c_in};
        x_nx = x_in;
        x_nx[k*CW +: CW] = sum[CW-1:0];
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          v_q <= 1'b0;
        end else if (en) begin
          v_q <= v_in;
        end
        // Bubbles leave the data registers untouched.
        if (en && v_in) begin
          x_q <= x_nx;
          y_q <= y_in[YI-1:CW];
          c_q <= sum[CW];
        end
      end
    end

    assign last_x = g_stage[STAGES-2].x_q;
    assign last_y = g_stage[STAGES-2].y_q;
    assign last_c = g_stage[STAGES-2].c_q;
    assign last_v = g_stage[STAGES-2].v_q;
  end

  logic [CW:0]      last_sum;
  logic [WIDTH-1:0] s_d;
  logic             cout_d;
  logic             ovf_d;
  logic             zero_d;
  logic             msb_cin;

  always_comb begin
    last_sum = {1'b0, last_x[WIDTH-1 -: CW]} + {1'b0, last_y} + {{CW{1'b0}}, last_c};
    s_d      = last_x;
    s_d[WIDTH-1 -: CW] = last_sum[CW-1:0];
    cout_d   = last_sum[CW];
    // Carry into the MSB recovered from the MSB sum bit and its two operand bits.
    msb_cin  = s_d[WIDTH-1] ^ last_x[WIDTH-1] ^ last_y[CW-1];
    ovf_d    = msb_cin ^ cout_d;
    zero_d   = (s_d == '0);
  end

  logic             out_valid_q;
  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      s_q         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else if (en) begin
      out_valid_q <= last_v;
      if (last_v) begin
        s_q    <= s_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed table and stall/reset sequences on the default
// 16/4 instance, plus random traffic on several WIDTH/STAGES configurations.
module tb_pipelined_addsub;

  localparam int unsigned W      = 16;
  localparam int unsigned S      = 4;
  localparam int          NSWEEP = 5;
  localparam int unsigned SW_W [NSWEEP] = '{16, 16, 16, 32, 8};
  localparam int unsigned SW_S [NSWEEP] = '{4, 1, 16, 4, 2};
  localparam int          NOPS   = 10000;
  localparam int          NVEC   = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference from signed/unsigned integer arithmetic, packed as {s, cout, ovf, zero}.
  function automatic logic [63:0] ref_addsub(input int unsigned w, input longint x,
                                             input longint y, input logic c, input logic m);
    longint lim, sx, sy, r, sr, rs;
    logic   co, ov;
    lim = longint'(1) << w;
    sx  = (x >= lim / 2) ? x - lim : x;
    sy  = (y >= lim / 2) ? y - lim : y;
    if (m) begin
      r  = x - y;
      co = (x >= y);
      sr = sx - sy;
    end else begin
      r  = x + y + longint'(c);
      co = (r >= lim);
      sr = sx + sy + longint'(c);
    end
    ov = (sr >= lim / 2) || (sr < -(lim / 2));
    rs = r & (lim - 1);
    return (64'(rs) << 3) | {61'b0, co, ov, rs == 0};
  endfunction

  // ---------------------------------------------------------------- default instance
  logic         m_reset, m_in_valid, m_in_ready, m_cin, m_sub;
  logic         m_out_valid, m_out_ready, m_cout, m_ovf, m_zero;
  logic [W-1:0] m_a, m_b, m_s;

  pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
    .clk      (clk),
    .reset    (m_reset),
    .in_valid (m_in_valid),
    .in_ready (m_in_ready),
    .a        (m_a),
    .b        (m_b),
    .cin      (m_cin),
    .sub      (m_sub),
    .out_valid(m_out_valid),
    .out_ready(m_out_ready),
    .s        (m_s),
    .cout     (m_cout),
    .ovf      (m_ovf),
    .zero     (m_zero)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  vec_t vecs [NVEC];

  initial begin
    int          lat, issued, got, stall_left, stale;
    logic        stall_seen;
    logic [15:0] e;

    vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{16'h1234, 16'h5678, 1'b1, 1'b1, 16'hBBBC, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    vecs[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0};

    m_reset = 1'b1; m_in_valid = 1'b0; m_out_ready = 1'b1;
    m_a = '0; m_b = '0; m_cin = 1'b0; m_sub = 1'b0;
    tick();
    tick();
    check("reset_out_valid", m_out_valid, 0);
    check("reset_s", m_s, 0);
    check("reset_flags", {m_cout, m_ovf, m_zero}, 0);
    check("reset_in_ready", m_in_ready, 1);
    m_reset = 1'b0;
    tick();

    // Single operations, latency and flags.
    for (int i = 0; i < NVEC; i++) begin
      m_a = vecs[i].a; m_b = vecs[i].b; m_cin = vecs[i].cin; m_sub = vecs[i].sub;
      m_in_valid = 1'b1;
      tick();
      m_in_valid = 1'b0;
      lat = 1;
      while (!m_out_valid && lat < 20) begin
        tick();
        lat++;
      end
      check($sformatf("vec%0d_latency", i), lat, S);
      check($sformatf("vec%0d_s", i), m_s, vecs[i].s);
      check($sformatf("vec%0d_cout", i), m_cout, vecs[i].cout);
      check($sformatf("vec%0d_ovf", i), m_ovf, vecs[i].ovf);
      check($sformatf("vec%0d_zero", i), m_zero, vecs[i].zero);
    end
    tick();

    // Six back-to-back ops (i + 0xFFFF) with a 3-cycle stall once results appear.
    issued = 0; got = 0; stall_left = 0; stall_seen = 1'b0;
    for (int cyc = 0; cyc < 100 && got < 6; cyc++) begin
      if (m_out_valid && !stall_seen) begin
        stall_seen = 1'b1;
        stall_left = 3;
      end
      m_out_ready = (stall_left == 0);
      m_in_valid  = (issued < 6);
      m_a = 16'(issued); m_b = 16'hFFFF; m_cin = 1'b0; m_sub = 1'b0;
      #1;
      e = 16'(got) + 16'hFFFF;
      if (stall_left > 0) begin
        check("stall_in_ready", m_in_ready, 0);
        check("stall_out_valid", m_out_valid, 1);
        check("stall_s_held", m_s, e);
        stall_left--;
      end
      if (m_out_valid && m_out_ready) begin
        check($sformatf("b2b_result%0d", got), m_s, e);
        got++;
      end
      if (m_in_valid && m_in_ready) issued++;
      tick();
    end
    check("b2b_count", got, 6);
    m_in_valid = 1'b0; m_out_ready = 1'b1;
    stale = 0;
    repeat (6) begin
      if (m_out_valid) stale++;
      tick();
    end
    check("b2b_no_duplicates", stale, 0);

    // Three ops in flight, reset during the third issue cycle.
    for (int i = 0; i < 3; i++) begin
      m_a = 16'(16'h0100 * (i + 1)); m_b = 16'h0011; m_sub = 1'b0; m_cin = 1'b0;
      m_in_valid = 1'b1;
      m_reset = (i == 2);
      tick();
    end
    m_out_ready = 1'b0;
    #1;
    check("midreset_out_valid", m_out_valid, 0);
    check("midreset_s", m_s, 0);
    check("midreset_in_ready", m_in_ready, 1);
    m_reset = 1'b0; m_in_valid = 1'b0; m_out_ready = 1'b1;
    stale = 0;
    repeat (8) begin
      tick();
      if (m_out_valid) stale++;
    end
    check("midreset_no_stale", stale, 0);

    wait (g_sweep[0].done && g_sweep[1].done && g_sweep[2].done && g_sweep[3].done &&
          g_sweep[4].done);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // ---------------------------------------------------------------- random sweep
  for (genvar g = 0; g < NSWEEP; g++) begin : g_sweep
    localparam int unsigned GW = SW_W[g];
    localparam int unsigned GS = SW_S[g];

    logic          rst, iv, ir, ov, ordy, ci, sb, co, of, zr;
    logic          done = 1'b0;
    logic [GW-1:0] ga, gb, gs;
    logic [63:0]   exp_q [$];
    int            age_q [$];

    pipelined_addsub #(.WIDTH(GW), .STAGES(GS)) u_dut (
      .clk      (clk),
      .reset    (rst),
      .in_valid (iv),
      .in_ready (ir),
      .a        (ga),
      .b        (gb),
      .cin      (ci),
      .sub      (sb),
      .out_valid(ov),
      .out_ready(ordy),
      .s        (gs),
      .cout     (co),
      .ovf      (of),
      .zero     (zr)
    );

    initial begin
      int    issued;
      logic  en, take, give;
      string tag;
      tag = $sformatf("w%0d_s%0d", GW, GS);
      issued = 0;
      rst = 1'b1; iv = 1'b0; ordy = 1'b0; ga = '0; gb = '0; ci = 1'b0; sb = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      for (int cyc = 0; cyc < 60000 && (issued < NOPS || exp_q.size() != 0); cyc++) begin
        iv   = (issued < NOPS) && ($urandom_range(0, 3) != 0);
        ga   = GW'($urandom);
        gb   = ($urandom_range(0, 7) == 0) ? ~ga : GW'($urandom);
        ci   = ($urandom_range(0, 1) == 1);
        sb   = ($urandom_range(0, 1) == 1);
        ordy = ($urandom_range(0, 3) != 0);
        #1;
        en   = !ov || ordy;
        take = iv && ir;
        give = ov && ordy;
        check({tag, "_in_ready"}, ir, en);
        if (ov && exp_q.size() == 0) begin
          check({tag, "_spurious_valid"}, ov, 0);
        end else if (give) begin
          check({tag, "_result"}, {gs, co, of, zr}, exp_q[0]);
          check({tag, "_latency"}, age_q[0], GS);
          void'(exp_q.pop_front());
          void'(age_q.pop_front());
        end
        if (en) begin
          foreach (age_q[j]) age_q[j]++;
        end
        if (take) begin
          exp_q.push_back(ref_addsub(GW, longint'(ga), longint'(gb), ci, sb));
          age_q.push_back(1);
          issued++;
        end
        tick();
      end
      check({tag, "_issued"}, issued, NOPS);
      check({tag, "_drained"}, exp_q.size(), 0);
      done = 1'b1;
    end
  end

endmodule
